// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default widths,
// the bubble control value and a small occupancy helper.
package pipe_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 12;
  localparam int DEF_CNT_W  = 16;

  // Control vector carried by a bubble: no RegWrite, MemWrite, HLT, ...
  localparam logic [DEF_CTRL_W-1:0] CTRL_NOP = '0;

  // One held entry at the default widths.
  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_CTRL_W-1:0] ctrl;
  } pipe_entry_t;

  // Number of valid entries among main and skid.
  function automatic logic [1:0] count_valid(input logic main_valid, input logic skid_valid);
    return {1'b0, main_valid} + {1'b0, skid_valid};
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle carrying a payload and a control vector.
interface pipe_skid_stage_if #(
  parameter int DATA_W = pipe_pkg::DEF_DATA_W,
  parameter int CTRL_W = pipe_pkg::DEF_CTRL_W
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/pipe_skid_stage_entry_reg.sv
// A single {valid, data, ctrl} holding register with write enable and a
// synchronous clear that drops the entry and zeroes its control vector.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic              clr,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  // Reset wipes everything, clear drops the entry, otherwise load on wen.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_ctrl  <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_W'(CTRL_NOP);
    end else if (wen) begin
      q_valid <= d_valid;
      q_data  <= d_data;
      q_ctrl  <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a 2-entry skid buffer so that the upstream
// ready is a flop output. Bubbles always present an all-zero control vector,
// flush squashes everything held, and a saturating counter tracks cycles in
// which the downstream was ready but starved.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_skid_stage_if.slave     up,
  pipe_skid_stage_if.master    dn,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic [CTRL_W-1:0] main_c, skid_c;

  logic              accept, emit;
  logic              main_wen, skid_wen, skid_clr;
  logic              main_nv;
  logic [DATA_W-1:0] main_nd;
  logic [CTRL_W-1:0] main_nc;

  // Handshake and steering: main refills from skid when skid holds an entry,
  // otherwise from upstream; an arrival that cannot reach main parks in skid.
  always_comb begin
    accept   = up.valid & ~skid_v;
    emit     = main_v & dn.ready;
    main_wen = emit | (accept & ~main_v);
    skid_wen = accept & main_v & ~emit;
    skid_clr = flush | (emit & skid_v);
    main_nv  = accept;
    main_nd  = up.data;
    main_nc  = accept ? up.ctrl : '0;
    if (skid_v) begin
      main_nv = 1'b1;
      main_nd = skid_d;
      main_nc = skid_c;
    end
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .wen     (main_wen),
    .clr     (flush),
    .d_valid (main_nv),
    .d_data  (main_nd),
    .d_ctrl  (main_nc),
    .q_valid (main_v),
    .q_data  (main_d),
    .q_ctrl  (main_c)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wen     (skid_wen),
    .clr     (skid_clr),
    .d_valid (1'b1),
    .d_data  (up.data),
    .d_ctrl  (up.ctrl),
    .q_valid (skid_v),
    .q_data  (skid_d),
    .q_ctrl  (skid_c)
  );

  assign up.ready  = ~skid_v;
  assign dn.valid  = main_v;
  assign dn.data   = main_d;
  assign dn.ctrl   = main_v ? main_c : '0;
  assign occupancy = count_valid(main_v, skid_v);

  // Count starved-downstream cycles, holding at the maximum; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (dn.ready && !main_v && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed reset/stream/stall/flush/
// counter sequences plus a constrained-random run against a queue scoreboard.
module tb_pipe_skid_stage;

  localparam int DW     = 64;
  localparam int CW     = 12;
  localparam int NW     = 4;
  localparam int CNTMAX = 15;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [1:0]    occupancy;
  logic [NW-1:0] bubble_cnt;

  pipe_skid_stage_if #(.DATA_W(DW), .CTRL_W(CW)) ifi ();
  pipe_skid_stage_if #(.DATA_W(DW), .CTRL_W(CW)) ifo ();

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .up         (ifi),
    .dn         (ifo),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } sb_t;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          fl;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          chk_od;
    logic [CW-1:0] e_oc;
    logic [1:0]    e_occ;
    logic          e_ir;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[11];
  int   errors;
  int   checks;
  int   model_cnt;
  logic prev_accept;
  logic rand_phase;
  logic hold_pend;
  sb_t  hold_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                               input logic ordy, input logic fl, input logic r);
    ifi.valid = iv;
    ifi.data  = d;
    ifi.ctrl  = c;
    ifo.ready = ordy;
    flush     = fl;
    rst       = r;
  endtask

  // Scoreboard monitor: compare outputs with the reference queue mid-cycle, then advance the model.
  always @(negedge clk) begin : monitor
    int   sz;
    logic acc, em;
    sz = sbq.size();
    checkOutput("sb_out_valid", {63'd0, ifo.valid}, {63'd0, sz > 0});
    checkOutput("sb_in_ready", {63'd0, ifi.ready}, {63'd0, sz < 2});
    checkOutput("sb_occupancy", {62'd0, occupancy}, 64'(sz));
    checkOutput("sb_bubble_cnt", {60'd0, bubble_cnt}, 64'(model_cnt));
    if (sz > 0) begin
      checkOutput("sb_out_data", ifo.data, sbq[0].data);
      checkOutput("sb_out_ctrl", {52'd0, ifo.ctrl}, {52'd0, sbq[0].ctrl});
    end else begin
      checkOutput("sb_bubble_ctrl", {52'd0, ifo.ctrl}, 64'd0);
    end
    if (rand_phase && hold_pend) begin
      assert (ifi.valid && ifi.data == hold_val.data && ifi.ctrl == hold_val.ctrl)
        else $error("[TB] upstream dropped a pending entry");
    end
    if (rst) begin
      sbq.delete();
      model_cnt   = 0;
      prev_accept = 1'b0;
      hold_pend   = 1'b0;
    end else begin
      acc = ifi.valid && (sz < 2);
      em  = (sz > 0) && ifo.ready;
      if (ifo.ready && sz == 0 && model_cnt < CNTMAX) model_cnt++;
      if (em) void'(sbq.pop_front());
      if (flush) sbq.delete();
      else if (acc) sbq.push_back({ifi.data, ifi.ctrl});
      prev_accept = acc;
      hold_pend   = ifi.valid && !acc;
      hold_val    = {ifi.data, ifi.ctrl};
    end
  end

  initial begin
    errors      = 0;
    checks      = 0;
    model_cnt   = 0;
    prev_accept = 1'b0;
    rand_phase  = 1'b0;
    hold_pend   = 1'b0;
    hold_val    = '0;

    // Stall/skid then flush vectors, applied from an empty stage.
    vecs[0]  = '{1'b1, 64'hA, 12'hFFF, 1'b0, 1'b0, 1'b1, 64'hA, 1'b1, 12'hFFF, 2'd1, 1'b1};
    vecs[1]  = '{1'b1, 64'hB, 12'hA5A, 1'b0, 1'b0, 1'b1, 64'hA, 1'b1, 12'hFFF, 2'd2, 1'b0};
    vecs[2]  = '{1'b0, 64'h0, 12'h000, 1'b0, 1'b0, 1'b1, 64'hA, 1'b1, 12'hFFF, 2'd2, 1'b0};
    vecs[3]  = '{1'b0, 64'h0, 12'h000, 1'b1, 1'b0, 1'b1, 64'hB, 1'b1, 12'hA5A, 2'd1, 1'b1};
    vecs[4]  = '{1'b0, 64'h0, 12'h000, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 12'h000, 2'd0, 1'b1};
    vecs[5]  = '{1'b1, 64'h51, 12'hFFF, 1'b0, 1'b0, 1'b1, 64'h51, 1'b1, 12'hFFF, 2'd1, 1'b1};
    vecs[6]  = '{1'b1, 64'h52, 12'hFFF, 1'b0, 1'b0, 1'b1, 64'h51, 1'b1, 12'hFFF, 2'd2, 1'b0};
    vecs[7]  = '{1'b1, 64'hC, 12'hFFF, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 12'h000, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 64'hD, 12'hFFF, 1'b0, 1'b0, 1'b1, 64'hD, 1'b1, 12'hFFF, 2'd1, 1'b1};
    vecs[9]  = '{1'b1, 64'hE, 12'hFFF, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 12'h000, 2'd0, 1'b1};
    vecs[10] = '{1'b0, 64'h0, 12'h000, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 12'h000, 2'd0, 1'b1};

    // Reset held for two cycles with a valid upstream entry.
    applyStimulus(1'b1, 64'hDEAD, 12'hFFF, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {63'd0, ifo.valid}, 64'd0);
    checkOutput("rst_out_ctrl", {52'd0, ifo.ctrl}, 64'd0);
    checkOutput("rst_out_data", ifo.data, 64'd0);
    checkOutput("rst_occupancy", {62'd0, occupancy}, 64'd0);
    checkOutput("rst_bubble_cnt", {60'd0, bubble_cnt}, 64'd0);
    applyStimulus(1'b0, 64'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {63'd0, ifi.ready}, 64'd1);

    // Back-to-back stream with downstream always ready.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 64'(i), 12'(i + 1), 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("stream_out_valid", {63'd0, ifo.valid}, 64'd1);
      checkOutput("stream_out_data", ifo.data, 64'(i));
      checkOutput("stream_in_ready", {63'd0, ifi.ready}, 64'd1);
    end
    applyStimulus(1'b0, 64'd0, 12'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("stream_drained", {63'd0, ifo.valid}, 64'd0);

    // Table: skid fill, ordered drain, flush with pending input.
    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].iv, vecs[v].d, vecs[v].c, vecs[v].ordy, vecs[v].fl, 1'b0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_out_valid", v), {63'd0, ifo.valid}, {63'd0, vecs[v].e_ov});
      checkOutput($sformatf("vec%0d_out_ctrl", v), {52'd0, ifo.ctrl}, {52'd0, vecs[v].e_oc});
      checkOutput($sformatf("vec%0d_occupancy", v), {62'd0, occupancy}, {62'd0, vecs[v].e_occ});
      checkOutput($sformatf("vec%0d_in_ready", v), {63'd0, ifi.ready}, {63'd0, vecs[v].e_ir});
      if (vecs[v].chk_od) checkOutput($sformatf("vec%0d_out_data", v), ifo.data, vecs[v].e_od);
    end

    // Counter saturation, with a flush in the middle that must not clear it.
    applyStimulus(1'b0, 64'd0, 12'd0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("cnt_after_rst", {60'd0, bubble_cnt}, 64'd0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 64'd0, 12'd0, 1'b1, (k == 10), 1'b0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("cnt_step%0d", k), {60'd0, bubble_cnt}, 64'((k < CNTMAX) ? k : CNTMAX));
    end

    // Constrained-random traffic checked by the scoreboard monitor.
    rand_phase = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!(ifi.valid && !prev_accept)) begin
        ifi.valid = ($urandom_range(0, 9) < 6);
        ifi.data  = {$urandom(), $urandom()};
        ifi.ctrl  = 12'($urandom_range(0, 4095));
      end
      ifo.ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      @(posedge clk);
      #1;
    end
    rand_phase = 1'b0;
    applyStimulus(1'b0, 64'd0, 12'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
